// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared definitions for the Hack-style memory arbiters: default word and
// address widths and the two-state access FSM encoding. Kept in a package so
// the ROM/IO arbiters can reuse the same encodings.
package ram_arbiter_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// rr_pick2
// Combinational two-way round-robin winner select.
// Ports:
//   req0_i, req1_i : request lines
//   last_i         : index of the requester that won most recently
//   winner_o       : index of the selected requester (only meaningful with any_req_o)
//   any_req_o      : at least one request is pending
module rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic winner_o,
    output logic any_req_o
);

    // Winner select: on contention the requester that did not win last time goes.
    always_comb begin
        any_req_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            winner_o = ~last_i;
        end else if (req1_i) begin
            winner_o = 1'b1;
        end else begin
            winner_o = 1'b0;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one combinational-read / clocked-write RAM8 between a CPU data port
// (requester 0) and a screen/DMA port (requester 1). One access per two
// cycles: IDLE samples requests and registers the winner's command, ACCESS
// presents it to the RAM for exactly one cycle and captures read data.
// Ports:
//   clk_i, rst_i              : clock, synchronous active-high reset
//   reqN_i/weN_i/addrN_i/wdataN_i : requester N command, held until grant
//   gntN_o                    : one-cycle grant pulse (during ACCESS)
//   rvalidN_o                 : one-cycle read-data-valid pulse (IDLE after ACCESS)
//   rdata_o                   : last captured read data, shared
//   ram_load_o/ram_addr_o/ram_din_o : registered RAM command
//   ram_dout_i                : RAM read data (combinational of ram_addr_o)
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              ram_load_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    input  logic [DATA_W-1:0] ram_dout_i
);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic              gnt0_r,    gnt0_nxt_s;
    logic              gnt1_r,    gnt1_nxt_s;
    logic              rvalid0_r, rvalid0_nxt_s;
    logic              rvalid1_r, rvalid1_nxt_s;
    logic              load_r,    load_nxt_s;
    logic [ADDR_W-1:0] addr_r,    addr_nxt_s;
    logic [DATA_W-1:0] din_r,     din_nxt_s;
    logic [DATA_W-1:0] rdata_r,   rdata_nxt_s;
    logic              last_r,    last_nxt_s;
    logic              winner_r,  winner_nxt_s;
    logic              pick_s;
    logic              any_req_s;

    rr_pick2 u_pick (
        .req0_i    (req0_i),
        .req1_i    (req1_i),
        .last_i    (last_r),
        .winner_o  (pick_s),
        .any_req_o (any_req_s)
    );

    // Next-state and next-output logic for the IDLE/ACCESS sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        gnt0_nxt_s    = 1'b0;
        gnt1_nxt_s    = 1'b0;
        rvalid0_nxt_s = 1'b0;
        rvalid1_nxt_s = 1'b0;
        load_nxt_s    = 1'b0;
        addr_nxt_s    = addr_r;
        din_nxt_s     = din_r;
        rdata_nxt_s   = rdata_r;
        last_nxt_s    = last_r;
        winner_nxt_s  = winner_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s  = ST_ACCESS;
                    winner_nxt_s = pick_s;
                    last_nxt_s   = pick_s;
                    if (pick_s) begin
                        gnt1_nxt_s = 1'b1;
                        load_nxt_s = we1_i;
                        addr_nxt_s = addr1_i;
                        din_nxt_s  = wdata1_i;
                    end else begin
                        gnt0_nxt_s = 1'b1;
                        load_nxt_s = we0_i;
                        addr_nxt_s = addr0_i;
                        din_nxt_s  = wdata0_i;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // The load register doubles as the in-flight write flag.
                state_nxt_s = ST_IDLE;
                if (!load_r) begin
                    rdata_nxt_s = ram_dout_i;
                    if (winner_r) begin
                        rvalid1_nxt_s = 1'b1;
                    end else begin
                        rvalid0_nxt_s = 1'b1;
                    end
                end else begin
                    rdata_nxt_s = rdata_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Command, handshake, read-data and round-robin registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            load_r    <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            din_r     <= {DATA_W{1'b0}};
            rdata_r   <= {DATA_W{1'b0}};
            last_r    <= 1'b1;
            winner_r  <= 1'b0;
        end else begin
            gnt0_r    <= gnt0_nxt_s;
            gnt1_r    <= gnt1_nxt_s;
            rvalid0_r <= rvalid0_nxt_s;
            rvalid1_r <= rvalid1_nxt_s;
            load_r    <= load_nxt_s;
            addr_r    <= addr_nxt_s;
            din_r     <= din_nxt_s;
            rdata_r   <= rdata_nxt_s;
            last_r    <= last_nxt_s;
            winner_r  <= winner_nxt_s;
        end
    end

    assign gnt0_o     = gnt0_r;
    assign gnt1_o     = gnt1_r;
    assign rvalid0_o  = rvalid0_r;
    assign rvalid1_o  = rvalid1_r;
    assign rdata_o    = rdata_r;
    assign ram_load_o = load_r;
    assign ram_addr_o = addr_r;
    assign ram_din_o  = din_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Scoreboard bench: the stimulus thread pushes expected grants and read data,
// a negedge monitor pops and compares whenever the arbiter presents a grant
// or an rvalid. A behavioural RAM8 (clocked write, combinational read) sits
// on the RAM side.
module tb_ram_arbiter;

    localparam int DW = 16;
    localparam int AW = 3;

    typedef struct {
        int          id;
        logic        we;
        logic [2:0]  addr;
        logic [15:0] data;
    } gexp_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req0_i, we0_i, req1_i, we1_i;
    logic [AW-1:0] addr0_i, addr1_i;
    logic [DW-1:0] wdata0_i, wdata1_i;
    logic          gnt0_o, gnt1_o, rvalid0_o, rvalid1_o;
    logic [DW-1:0] rdata_o;
    logic          ram_load_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_din_o;
    logic [DW-1:0] ram_dout_i;

    logic [DW-1:0] mem [0:7] = '{default: 16'h0000};

    gexp_t         gq[$];
    logic [15:0]   rq0[$];
    logic [15:0]   rq1[$];
    int            checks = 0;
    int            errors = 0;
    int            load_cnt = 0;
    int            rv_cnt = 0;

    ram_arbiter dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req0_i     (req0_i),
        .we0_i      (we0_i),
        .addr0_i    (addr0_i),
        .wdata0_i   (wdata0_i),
        .req1_i     (req1_i),
        .we1_i      (we1_i),
        .addr1_i    (addr1_i),
        .wdata1_i   (wdata1_i),
        .gnt0_o     (gnt0_o),
        .gnt1_o     (gnt1_o),
        .rvalid0_o  (rvalid0_o),
        .rvalid1_o  (rvalid1_o),
        .rdata_o    (rdata_o),
        .ram_load_o (ram_load_o),
        .ram_addr_o (ram_addr_o),
        .ram_din_o  (ram_din_o),
        .ram_dout_i (ram_dout_i)
    );

    always #5 clk = ~clk;

    // RAM8 model: write on the clock edge while load is high, combinational read.
    always @(posedge clk) begin
        if (ram_load_o) mem[ram_addr_o] <= ram_din_o;
    end
    assign ram_dout_i = mem[ram_addr_o];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every grant and every rvalid against the scoreboard queues.
    always @(negedge clk) begin
        gexp_t e;
        if (gnt0_o || gnt1_o) begin
            if (gq.size() == 0) begin
                chk("gnt_unexpected", {30'd0, gnt1_o, gnt0_o}, 32'd0);
            end else begin
                e = gq.pop_front();
                chk("gnt_id", {30'd0, gnt1_o, gnt0_o}, (e.id == 1) ? 32'd2 : 32'd1);
                chk("gnt_load", {31'd0, ram_load_o}, {31'd0, e.we});
                chk("gnt_addr", {29'd0, ram_addr_o}, {29'd0, e.addr});
                if (e.we) chk("gnt_din", {16'd0, ram_din_o}, {16'd0, e.data});
            end
        end
        if (ram_load_o && !gnt0_o && !gnt1_o)
            chk("load_outside_access", {31'd0, ram_load_o}, 32'd0);
        if (ram_load_o) load_cnt++;
        if (rvalid0_o) begin
            rv_cnt++;
            if (rq0.size() == 0) chk("rvalid0_unexpected", {31'd0, rvalid0_o}, 32'd0);
            else chk("rdata0", {16'd0, rdata_o}, {16'd0, rq0.pop_front()});
        end
        if (rvalid1_o) begin
            rv_cnt++;
            if (rq1.size() == 0) chk("rvalid1_unexpected", {31'd0, rvalid1_o}, 32'd0);
            else chk("rdata1", {16'd0, rdata_o}, {16'd0, rq1.pop_front()});
        end
    end

    task automatic set_req(input int id, input logic req, input logic we,
                           input logic [2:0] addr, input logic [15:0] data);
        if (id == 1) begin
            req1_i = req; we1_i = we; addr1_i = addr; wdata1_i = data;
        end else begin
            req0_i = req; we0_i = we; addr0_i = addr; wdata0_i = data;
        end
    endtask

    task automatic push_exp(input int id, input logic we, input logic [2:0] addr,
                            input logic [15:0] data, input logic [15:0] rd);
        gexp_t e;
        e.id = id; e.we = we; e.addr = addr; e.data = data;
        gq.push_back(e);
        if (!we) begin
            if (id == 1) rq1.push_back(rd);
            else rq0.push_back(rd);
        end
    endtask

    // Wait (bounded) for the grant of requester id; returns the number of edges taken.
    task automatic wait_gnt(input int id, output int edges);
        logic got;
        got = 1'b0;
        edges = 0;
        while (!got && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            got = (id == 1) ? gnt1_o : gnt0_o;
        end
        if (!got) chk("gnt_timeout", {31'd0, got}, 32'd1);
    endtask

    // One complete access from a single requester; returns in the following IDLE cycle.
    task automatic do_access(input int id, input logic we, input logic [2:0] addr,
                             input logic [15:0] data, input logic [15:0] rd, input bit check_lat);
        int ed;
        push_exp(id, we, addr, data, rd);
        set_req(id, 1'b1, we, addr, data);
        wait_gnt(id, ed);
        set_req(id, 1'b0, 1'b0, 3'd0, 16'h0000);
        if (check_lat) chk("grant_latency", ed, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ed;
        logic [2:0]  da [4];
        logic [15:0] dd [4];

        // Reset with both requesters asking for a read of address 0.
        rst_i = 1'b1;
        set_req(0, 1'b1, 1'b0, 3'd0, 16'h0000);
        set_req(1, 1'b1, 1'b0, 3'd0, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", {27'd0, gnt1_o, gnt0_o, rvalid1_o, rvalid0_o, ram_load_o}, 32'd0);
        chk("rst_addr", {29'd0, ram_addr_o}, 32'd0);
        chk("rst_din", {16'd0, ram_din_o}, 32'd0);
        chk("rst_rdata", {16'd0, rdata_o}, 32'd0);
        push_exp(0, 1'b0, 3'd0, 16'h0000, 16'h0000);
        rst_i = 1'b0;
        wait_gnt(0, ed);
        set_req(0, 1'b0, 1'b0, 3'd0, 16'h0000);
        set_req(1, 1'b0, 1'b0, 3'd0, 16'h0000);
        chk("first_grant_latency", ed, 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Single write then read-back with T+2 read latency.
        do_access(0, 1'b1, 3'd5, 16'hBEEF, 16'h0000, 1'b1);
        do_access(0, 1'b0, 3'd5, 16'h0000, 16'hBEEF, 1'b1);
        chk("rvalid0_at_T2", {31'd0, rvalid0_o}, 32'd1);
        chk("rdata_at_T2", {16'd0, rdata_o}, 32'h0000BEEF);

        // Preload addr 1 and 2; requester 1 is the last winner afterwards.
        do_access(0, 1'b1, 3'd1, 16'h1111, 16'h0000, 1'b1);
        do_access(1, 1'b1, 3'd2, 16'h2222, 16'h0000, 1'b1);

        // Contention: both hold reads for 8 cycles, grants alternate 0,1,0,1.
        push_exp(0, 1'b0, 3'd1, 16'h0000, 16'h1111);
        push_exp(1, 1'b0, 3'd2, 16'h0000, 16'h2222);
        push_exp(0, 1'b0, 3'd1, 16'h0000, 16'h1111);
        push_exp(1, 1'b0, 3'd2, 16'h0000, 16'h2222);
        set_req(0, 1'b1, 1'b0, 3'd1, 16'h0000);
        set_req(1, 1'b1, 1'b0, 3'd2, 16'h0000);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            chk("contend_gnt0", {31'd0, gnt0_o}, (c == 1 || c == 5) ? 32'd1 : 32'd0);
            chk("contend_gnt1", {31'd0, gnt1_o}, (c == 3 || c == 7) ? 32'd1 : 32'd0);
        end
        set_req(0, 1'b0, 1'b0, 3'd0, 16'h0000);
        set_req(1, 1'b0, 1'b0, 3'd0, 16'h0000);
        repeat (2) @(posedge clk);
        #1;

        // Single requester back-to-back reads, command changed after each grant.
        da = '{3'd5, 3'd1, 3'd2, 3'd5};
        dd = '{16'hBEEF, 16'h1111, 16'h2222, 16'hBEEF};
        for (int k = 0; k < 4; k++) push_exp(1, 1'b0, da[k], 16'h0000, dd[k]);
        set_req(1, 1'b1, 1'b0, da[0], 16'h0000);
        for (int k = 0; k < 4; k++) begin
            wait_gnt(1, ed);
            chk("b2b_spacing", ed, (k == 0) ? 32'd1 : 32'd2);
            if (k < 3) set_req(1, 1'b1, 1'b0, da[k+1], 16'h0000);
            else set_req(1, 1'b0, 1'b0, 3'd0, 16'h0000);
        end
        repeat (2) @(posedge clk);
        #1;

        // Write-only traffic to every address.
        load_cnt = 0;
        rv_cnt = 0;
        for (int a = 0; a < 8; a++)
            do_access(a % 2, 1'b1, 3'(a), 16'hA000 + 16'(a), 16'h0000, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("write_only_loads", load_cnt, 32'd8);
        chk("write_only_rvalids", rv_cnt, 32'd0);

        // Reset during the ACCESS cycle of a read: no rvalid may follow.
        push_exp(0, 1'b0, 3'd4, 16'h0000, 16'h0000);
        rq0.delete();
        set_req(0, 1'b1, 1'b0, 3'd4, 16'h0000);
        wait_gnt(0, ed);
        set_req(0, 1'b0, 1'b0, 3'd0, 16'h0000);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        chk("midrst_rd_rvalid0", {31'd0, rvalid0_o}, 32'd0);
        chk("midrst_rd_load", {31'd0, ram_load_o}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_rd_rvalid0_late", {31'd0, rvalid0_o}, 32'd0);

        // Reset during the ACCESS cycle of a write: the write still commits.
        push_exp(1, 1'b1, 3'd3, 16'h3C3C, 16'h0000);
        set_req(1, 1'b1, 1'b1, 3'd3, 16'h3C3C);
        wait_gnt(1, ed);
        chk("post_reset_idle_latency", ed, 32'd1);
        set_req(1, 1'b0, 1'b0, 3'd0, 16'h0000);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        chk("midrst_wr_load", {31'd0, ram_load_o}, 32'd0);
        do_access(0, 1'b0, 3'd3, 16'h0000, 16'h3C3C, 1'b1);
        chk("midrst_wr_readback", {16'd0, rdata_o}, 32'h00003C3C);
        repeat (2) @(posedge clk);
        #1;

        chk("grant_queue_drained", gq.size(), 32'd0);
        chk("read_queues_drained", rq0.size() + rq1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
